// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin arbiter with grant lock and bounded hold time
module rr_arbiter3 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       expired
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] MAX = 8'(MAX_HOLD);
  state_t     state_q, state_d;
  logic [1:0] last_id_q, last_id_d, gnt_id_q, gnt_id_d, p0, p1, p2, win;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] gnt_q, gnt_d;
  logic       busy_q, busy_d, expired_q, expired_d, own_req;
  always_comb begin
    p0 = last_id_q == 2'd2 ? 2'd0 : last_id_q + 2'd1;
    p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    win = req[p0] ? p0 : req[p1] ? p1 : p2;
    own_req = gnt_id_q != 2'd3 && req[gnt_id_q];
  end
  always_comb begin
    state_d = state_q;
    last_id_d = last_id_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d = busy_q;
    expired_d = 1'b0;
    if (state_q == IDLE) begin
      if (req != 3'b000) begin
        state_d = GRANT;
        gnt_d = 3'b001 << win;
        gnt_id_d = win;
        last_id_d = win;
        busy_d = 1'b1;
        hold_cnt_d = 8'd1;
      end
    end else if (own_req && hold_cnt_q < MAX) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end else begin
      // owner still requesting here means the hold limit forced the release
      state_d = IDLE;
      gnt_d = 3'b000;
      gnt_id_d = 2'd3;
      busy_d = 1'b0;
      hold_cnt_d = 8'd0;
      expired_d = own_req;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_id_q <= 2'd2;
      hold_cnt_q <= 8'd0;
      gnt_q <= 3'b000;
      gnt_id_q <= 2'd3;
      busy_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_id_q <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q <= busy_d;
      expired_q <= expired_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy = busy_q;
  assign expired = expired_q;
endmodule
